// File: rtl/dds_lut_sequencer.sv
// DDS phase-accumulator sequencer: Avalon-MM control, sample-tick-driven lookup-RAM reads, 3-cycle tick-to-valid.
// Optional phase offset register and adder when DDS_SEQ_PHASE_OFFSET_EN is defined.
module dds_lut_sequencer #(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_write,
    input  logic              s_read,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    input  logic              sample_tick,
    output logic [LUT_AW-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    input  logic [15:0]       ram_readdata,
    output logic [15:0]       sample_data,
    output logic              sample_valid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [31:0]       r_ftw_shadow;
    logic [31:0]       r_ftw_active;
    logic              r_pending;
    logic [LUT_AW-1:0] r_ram_address;
    logic              r_ram_cs;
    logic              r_capture;
    logic [15:0]       r_sample_data;
    logic              r_sample_valid;
    logic [31:0]       r_readdata;

    logic              w_wr;
    logic              w_rd;
    logic              w_wr_ctrl;
    logic              w_wr_ftw;
    logic              w_wr_update;
    logic              w_pclr;
    logic              w_tick;
    logic              w_commit;
    logic [31:0]       w_ftw_eff;
    logic [31:0]       w_poff_eff;
    logic [31:0]       w_poff_rd;
    logic [ACC_W-1:0]  w_base;
    logic [ACC_W-1:0]  w_addr_phase;
    logic [LUT_AW-1:0] w_lut_addr;
    logic [31:0]       w_rdata;

    assign w_wr        = s_chipselect & s_write;
    assign w_rd        = s_chipselect & s_read;
    assign w_wr_ctrl   = w_wr && (s_address == 3'd0);
    assign w_wr_ftw    = w_wr && (s_address == 3'd1);
    assign w_wr_update = w_wr && (s_address == 3'd3);
    assign w_pclr      = w_wr_ctrl & s_writedata[1];

    // A commit only happens on a tick that finds pending already registered, so an
    // UPDATE write landing on the tick cycle itself waits for the following tick.
    assign w_tick    = (r_state == ST_RUN) & sample_tick;
    assign w_commit  = w_tick & r_pending;
    assign w_ftw_eff = w_commit ? r_ftw_shadow : r_ftw_active;

`ifdef DDS_SEQ_PHASE_OFFSET_EN
    logic        w_wr_poff;
    logic [31:0] r_poff_shadow;
    logic [31:0] r_poff_active;

    assign w_wr_poff = w_wr && (s_address == 3'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poff_shadow <= '0;
            r_poff_active <= '0;
        end else begin
            if (w_wr_poff) r_poff_shadow <= s_writedata;
            if (w_commit)  r_poff_active <= r_poff_shadow;
        end
    end

    assign w_poff_eff = w_commit ? r_poff_shadow : r_poff_active;
    assign w_poff_rd  = r_poff_shadow;
`else
    assign w_poff_eff = '0;
    assign w_poff_rd  = '0;
`endif

    // PCLR overrides the accumulator for this tick's address as well as its next value.
    assign w_base       = w_pclr ? '0 : r_acc;
    assign w_addr_phase = w_base + ACC_W'(w_poff_eff);
    assign w_lut_addr   = LUT_AW'(w_addr_phase >> (ACC_W - LUT_AW));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            if (w_wr_ctrl && s_writedata[0]) r_state <= ST_RUN;
        end else begin
            if (w_wr_ctrl && !s_writedata[0]) r_state <= ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ftw_shadow <= '0;
            r_ftw_active <= '0;
            r_pending    <= 1'b0;
            r_acc        <= '0;
        end else begin
            if (w_wr_ftw) r_ftw_shadow <= s_writedata;
            if (w_commit) r_ftw_active <= r_ftw_shadow;
            if (w_wr_update)   r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;
            if (w_pclr)      r_acc <= '0;
            else if (w_tick) r_acc <= r_acc + ACC_W'(w_ftw_eff);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_address  <= '0;
            r_ram_cs       <= 1'b0;
            r_capture      <= 1'b0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (w_tick) r_ram_address <= w_lut_addr;
            r_ram_cs       <= w_tick;
            r_capture      <= r_ram_cs;
            r_sample_valid <= r_capture;
            if (r_capture) r_sample_data <= ram_readdata;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rdata = '0;
        case (s_address)
            3'd0:    w_rdata = {31'd0, r_state == ST_RUN};
            3'd1:    w_rdata = r_ftw_shadow;
            3'd2:    w_rdata = w_poff_rd;
            3'd4:    w_rdata = {30'd0, r_pending, r_state == ST_RUN};
            3'd5:    w_rdata = 32'(r_acc);
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_readdata <= '0;
        else if (w_rd) r_readdata <= w_rdata;
    end

    assign s_readdata     = r_readdata;
    assign ram_address    = r_ram_address;
    assign ram_chipselect = r_ram_cs;
    assign ram_clken      = 1'b1;
    assign sample_data    = r_sample_data;
    assign sample_valid   = r_sample_valid;

endmodule

// File: tb/tb_dds_lut_sequencer.sv
// Directed bench for dds_lut_sequencer with a behavioural lookup RAM holding 16'hA000 | address.
module tb_dds_lut_sequencer;

    localparam int ACC_W  = 32;
    localparam int LUT_AW = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [2:0]        s_address = '0;
    logic              s_chipselect = 1'b0;
    logic              s_write = 1'b0;
    logic              s_read = 1'b0;
    logic [31:0]       s_writedata = '0;
    logic [31:0]       s_readdata;
    logic              sample_tick = 1'b0;
    logic [LUT_AW-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_clken;
    logic [15:0]       ram_readdata;
    logic [15:0]       sample_data;
    logic              sample_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [LUT_AW-1:0] ram_q = '0;

    dds_lut_sequencer #(.ACC_W(ACC_W), .LUT_AW(LUT_AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write(s_write),
        .s_read(s_read), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .sample_tick(sample_tick),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .sample_data(sample_data), .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    // Lookup RAM: registered address, unregistered data.
    always @(posedge clk) if (ram_chipselect && ram_clken) ram_q <= ram_address;
    assign ram_readdata = 16'hA000 | {6'd0, ram_q};

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(negedge clk);
        d = s_readdata;
        s_chipselect = 1'b0; s_read = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", sample_valid); else n_pass++;
        n_checks++; if (s_readdata !== 32'd0) $display("FAIL reset_readdata: got %0h want 0", s_readdata); else n_pass++;
        n_checks++; if (ram_chipselect !== 1'b0) $display("FAIL reset_ram_cs: got %0h want 0", ram_chipselect); else n_pass++;
        n_checks++; if (ram_clken !== 1'b1) $display("FAIL ram_clken: got %0h want 1", ram_clken); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ram_address !== '0) $display("FAIL reset_ram_addr: got %0h want 0", ram_address); else n_pass++;
        n_checks++; if (sample_data !== 16'd0) $display("FAIL reset_sample_data: got %0h want 0", sample_data); else n_pass++;
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL reset_status: got %0h want 0", rd); else n_pass++;
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL reset_phase: got %0h want 0", rd); else n_pass++;
    endtask

    task automatic test_idle_ignore();
        logic [31:0] rd;
        int activity = 0;
        bus_write(3'd1, 32'h0040_0000);
        sample_tick = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_chipselect || sample_valid) activity++;
        end
        sample_tick = 1'b0;
        n_checks++; if (activity !== 0) $display("FAIL idle_activity: got %0d want 0", activity); else n_pass++;
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL idle_phase: got %0h want 0", rd); else n_pass++;
    endtask

    task automatic test_sequence();
        logic [31:0] rd;
        bus_write(3'd1, 32'h0040_0000);
        bus_write(3'd3, 32'd0);
        bus_write(3'd0, 32'd1);
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd3) $display("FAIL seq_status_pending: got %0h want 3", rd); else n_pass++;
        for (int n = 0; n < 4; n++) begin
            pulse_tick();
            n_checks++; if (ram_address !== LUT_AW'(n) || ram_chipselect !== 1'b1)
                $display("FAIL seq_addr[%0d]: got addr %0d cs %0h want addr %0d cs 1", n, ram_address, ram_chipselect, n); else n_pass++;
            @(negedge clk);
            n_checks++; if (ram_chipselect !== 1'b0 || sample_valid !== 1'b0)
                $display("FAIL seq_t2[%0d]: got cs %0h valid %0h want 0 0", n, ram_chipselect, sample_valid); else n_pass++;
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b1 || sample_data !== (16'hA000 + 16'(n)))
                $display("FAIL seq_sample[%0d]: got valid %0h data %0h want 1 %0h", n, sample_valid, sample_data, 16'hA000 + 16'(n)); else n_pass++;
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b0 || sample_data !== (16'hA000 + 16'(n)))
                $display("FAIL seq_hold[%0d]: got valid %0h data %0h want 0 %0h", n, sample_valid, sample_data, 16'hA000 + 16'(n)); else n_pass++;
        end
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'h0100_0000) $display("FAIL seq_phase: got %0h want 01000000", rd); else n_pass++;
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd1) $display("FAIL seq_status_done: got %0h want 1", rd); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic [LUT_AW-1:0] exp_a [3];
        exp_a = '{10'd0, 10'd1023, 10'd1022};
        bus_write(3'd1, 32'hFFC0_0000);
        bus_write(3'd3, 32'd0);
        bus_write(3'd0, 32'd3);
        for (int n = 0; n < 3; n++) begin
            pulse_tick();
            n_checks++; if (ram_address !== exp_a[n]) $display("FAIL wrap_addr[%0d]: got %0d want %0d", n, ram_address, exp_a[n]); else n_pass++;
            repeat (2) @(negedge clk);
            n_checks++; if (sample_valid !== 1'b1 || sample_data !== (16'hA000 | {6'd0, exp_a[n]}))
                $display("FAIL wrap_sample[%0d]: got valid %0h data %0h want 1 %0h", n, sample_valid, sample_data, 16'hA000 | {6'd0, exp_a[n]}); else n_pass++;
            @(negedge clk);
        end
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'hFF40_0000) $display("FAIL wrap_phase: got %0h want ff400000", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        bus_write(3'd1, 32'h0040_0000);
        bus_write(3'd3, 32'd0);
        bus_write(3'd0, 32'd3);
        for (int c = 0; c < 24; c++) begin
            if (sample_valid) begin
                if (first < 0) first = c;
                last = c;
                n_checks++; if (sample_data !== (16'hA000 + 16'(cnt)))
                    $display("FAIL b2b_data[%0d]: got %0h want %0h", cnt, sample_data, 16'hA000 + 16'(cnt)); else n_pass++;
                cnt++;
            end
            sample_tick = (c < 16);
            @(negedge clk);
        end
        sample_tick = 1'b0;
        n_checks++; if (cnt !== 16) $display("FAIL b2b_count: got %0d want 16", cnt); else n_pass++;
        n_checks++; if (first !== 3 || last !== 18) $display("FAIL b2b_span: got %0d..%0d want 3..18", first, last); else n_pass++;
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'h0400_0000) $display("FAIL b2b_phase: got %0h want 04000000", rd); else n_pass++;
    endtask

    task automatic test_update_with_tick();
        logic [31:0] rd;
        bus_write(3'd0, 32'd3);
        pulse_tick();
        n_checks++; if (ram_address !== 10'd0) $display("FAIL upd_addr_a: got %0d want 0", ram_address); else n_pass++;
        bus_write(3'd1, 32'h0080_0000);
        sample_tick = 1'b1;
        s_chipselect = 1'b1; s_write = 1'b1; s_address = 3'd3; s_writedata = 32'd0;
        @(negedge clk);
        sample_tick = 1'b0; s_chipselect = 1'b0; s_write = 1'b0;
        n_checks++; if (ram_address !== 10'd1) $display("FAIL upd_addr_b: got %0d want 1", ram_address); else n_pass++;
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd3) $display("FAIL upd_status_set: got %0h want 3", rd); else n_pass++;
        pulse_tick();
        n_checks++; if (ram_address !== 10'd2) $display("FAIL upd_addr_c: got %0d want 2", ram_address); else n_pass++;
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd1) $display("FAIL upd_status_clr: got %0h want 1", rd); else n_pass++;
        pulse_tick();
        n_checks++; if (ram_address !== 10'd4) $display("FAIL upd_addr_d: got %0d want 4", ram_address); else n_pass++;
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'h0180_0000) $display("FAIL upd_phase: got %0h want 01800000", rd); else n_pass++;
    endtask

    task automatic test_pclr_with_tick();
        logic [31:0] rd;
        logic [LUT_AW-1:0] exp_addr;
        logic [31:0] exp_poff;
`ifdef DDS_SEQ_PHASE_OFFSET_EN
        exp_addr = 10'd512;
        exp_poff = 32'h8000_0000;
`else
        exp_addr = 10'd0;
        exp_poff = 32'd0;
`endif
        bus_write(3'd2, 32'h8000_0000);
        bus_write(3'd3, 32'd0);
        pulse_tick();
        repeat (3) @(negedge clk);
        sample_tick = 1'b1;
        s_chipselect = 1'b1; s_write = 1'b1; s_address = 3'd0; s_writedata = 32'd3;
        @(negedge clk);
        sample_tick = 1'b0; s_chipselect = 1'b0; s_write = 1'b0;
        n_checks++; if (ram_address !== exp_addr) $display("FAIL pclr_addr: got %0d want %0d", ram_address, exp_addr); else n_pass++;
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL pclr_phase: got %0h want 0", rd); else n_pass++;
        bus_read(3'd2, rd);
        n_checks++; if (rd !== exp_poff) $display("FAIL poff_read: got %0h want %0h", rd, exp_poff); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_run_clear();
        logic [31:0] rd;
        int cnt  = 0;
        int last = -1;
        for (int c = 0; c < 8; c++) begin
            if (sample_valid) begin cnt++; last = c; end
            sample_tick = (c < 3);
            if (c == 1) begin
                s_chipselect = 1'b1; s_write = 1'b1; s_address = 3'd0; s_writedata = 32'd0;
            end else begin
                s_chipselect = 1'b0; s_write = 1'b0;
            end
            @(negedge clk);
        end
        sample_tick = 1'b0; s_chipselect = 1'b0; s_write = 1'b0;
        n_checks++; if (cnt !== 2 || last !== 4) $display("FAIL runclr_valids: got %0d last %0d want 2 last 4", cnt, last); else n_pass++;
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'h0100_0000) $display("FAIL runclr_phase: got %0h want 01000000", rd); else n_pass++;
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL runclr_status: got %0h want 0", rd); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd;
        int activity = 0;
        bus_write(3'd0, 32'd1);
        pulse_tick();
        @(negedge clk);
        @(posedge clk);
        #2;
        n_checks++; if (sample_valid !== 1'b1) $display("FAIL rst_inflight: got %0h want 1", sample_valid); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (sample_valid !== 1'b0 || sample_data !== 16'd0)
            $display("FAIL rst_async: got valid %0h data %0h want 0 0", sample_valid, sample_data); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(3'd5, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL rst_phase: got %0h want 0", rd); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            sample_tick = (c < 6);
            @(negedge clk);
            if (ram_chipselect || sample_valid) activity++;
        end
        sample_tick = 1'b0;
        n_checks++; if (activity !== 0) $display("FAIL rst_quiet: got %0d want 0", activity); else n_pass++;
        bus_read(3'd4, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL rst_status: got %0h want 0", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_sequence();
        test_wrap();
        test_back_to_back();
        test_update_with_tick();
        test_pclr_with_tick();
        test_run_clear();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
